// File: rtl/data_path_muxs_pkg.sv
// Shared datapath mux selections and sequencer state encoding.
// Contents:
//   pc_mux_input_selection - PC next-value source (PC_NPC, PC_BRANCH, PC_JUMP, PC_JR)
//   pcseq_state_t          - pc_sequencer FSM states (IDLE, FETCH, MEM, HALTED)
//   pc_select()            - control-flow priority: jr > jump > branch > npc
package data_path_muxs_pkg;

    typedef enum logic [1:0] {
        PC_NPC    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_JR     = 2'd3
    } pc_mux_input_selection;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        MEM    = 2'd2,
        HALTED = 2'd3
    } pcseq_state_t;

    // Halt is resolved by the FSM, so only the PC redirects are ranked here.
    function automatic pc_mux_input_selection pc_select(input logic jr, input logic jmp,
                                                        input logic br);
        if (jr)       return PC_JR;
        else if (jmp) return PC_JUMP;
        else if (br)  return PC_BRANCH;
        else          return PC_NPC;
    endfunction

endpackage

// File: rtl/pc_sequencer_counter.sv
// pcseq_counter: free-running event counter, wraps modulo 2^CNT_W.
// Ports:
//   CLK   in  1      clock
//   nRST  in  1      async active-low reset (clears count)
//   en    in  1      count enable
//   clear in  1      synchronous clear (wins over en)
//   cnt   out CNT_W  current count
module pcseq_counter #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             en,
    input  logic             clear,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)      r_cnt <= '0;
        else if (clear) r_cnt <= '0;
        else if (en)    r_cnt <= r_cnt + 1'b1;
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/memory sequencer driving the PC controls (PCSrc, pc_wait, halt).
// Captures decode results on ihit, holds the PC through a data access and
// lets it advance exactly once per retired instruction.
// Ports:
//   CLK, nRST                         clock, async active-low reset
//   ihit, dhit                        memory handshakes
//   dREN_dec, dWEN_dec                decoded load / store
//   jump_dec, jr_dec, branch_taken    decoded control flow
//   halt_dec                          decoded HALT
//   imemREN, dmemREN, dmemWEN         memory requests
//   PCSrc, pc_wait, halt              PC controls
//   instr_cnt, stall_cnt              performance counters
// Configuration: define PCSEQ_PERF_EN to build the counters; otherwise they read 0.
module pc_sequencer
    import data_path_muxs_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  ihit,
    input  logic                  dhit,
    input  logic                  dREN_dec,
    input  logic                  dWEN_dec,
    input  logic                  jump_dec,
    input  logic                  jr_dec,
    input  logic                  branch_taken,
    input  logic                  halt_dec,
    output logic                  imemREN,
    output logic                  dmemREN,
    output logic                  dmemWEN,
    output pc_mux_input_selection PCSrc,
    output logic                  pc_wait,
    output logic                  halt,
    output logic [CNT_W-1:0]      instr_cnt,
    output logic [CNT_W-1:0]      stall_cnt
);

    pcseq_state_t          r_state, w_next;
    pc_mux_input_selection r_src, w_sel;
    logic                  r_dren, r_dwen;
    logic                  w_latch;

    assign w_sel   = pc_select(jr_dec, jump_dec, branch_taken);
    // A memory instruction parks its PC selection until the data side answers.
    assign w_latch = (r_state == FETCH) && ihit && !halt_dec && (dREN_dec || dWEN_dec);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_src   <= PC_NPC;
            r_dren  <= 1'b0;
            r_dwen  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_src  <= w_sel;
                r_dren <= dREN_dec;
                r_dwen <= dWEN_dec;
            end
        end
    end

    always_comb begin
        w_next  = r_state;
        imemREN = 1'b0;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
        PCSrc   = PC_NPC;
        pc_wait = 1'b1;
        halt    = 1'b0;
        unique case (r_state)
            IDLE: w_next = FETCH;
            FETCH: begin
                imemREN = 1'b1;
                if (ihit) begin
                    if (halt_dec)                   w_next = HALTED;
                    else if (dREN_dec || dWEN_dec)  w_next = MEM;
                    else begin
                        pc_wait = 1'b0;
                        PCSrc   = w_sel;
                    end
                end
            end
            MEM: begin
                dmemREN = r_dren;
                dmemWEN = r_dwen && !r_dren;  // a read/write collision resolves to the read
                if (dhit) begin
                    pc_wait = 1'b0;
                    PCSrc   = r_src;
                    w_next  = FETCH;
                end
            end
            HALTED: halt = 1'b1;
            default: w_next = IDLE;
        endcase
    end

`ifdef PCSEQ_PERF_EN
    logic w_stall_en;
    // HALTED and IDLE hold pc_wait=1 but are not stalls.
    assign w_stall_en = pc_wait && ((r_state == FETCH) || (r_state == MEM));

    pcseq_counter #(.CNT_W(CNT_W)) u_instr_cnt (
        .CLK(CLK), .nRST(nRST), .en(!pc_wait), .clear(1'b0), .cnt(instr_cnt)
    );
    pcseq_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK(CLK), .nRST(nRST), .en(w_stall_en), .clear(1'b0), .cnt(stall_cnt)
    );
`else
    assign instr_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
    import data_path_muxs_pkg::*;

    localparam int CNT_W = 4;

    logic CLK = 1'b0;
    logic nRST, ihit, dhit, dREN_dec, dWEN_dec, jump_dec, jr_dec, branch_taken, halt_dec;
    logic imemREN, dmemREN, dmemWEN, pc_wait, halt;
    pc_mux_input_selection PCSrc;
    logic [CNT_W-1:0] instr_cnt, stall_cnt;

    always #5 CLK = ~CLK;

    pc_sequencer #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .dREN_dec(dREN_dec), .dWEN_dec(dWEN_dec), .jump_dec(jump_dec), .jr_dec(jr_dec),
        .branch_taken(branch_taken), .halt_dec(halt_dec),
        .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .PCSrc(PCSrc), .pc_wait(pc_wait), .halt(halt),
        .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
    );

    int passed = 0;
    int total  = 0;
    pc_mux_input_selection exp_q[$];   // expected PCSrc of each retirement, in order
    logic [CNT_W-1:0] m_instr = '0, m_stall = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drv(input logic ih, dh, dr, dw, j, jr, br, hd);
        ihit = ih; dhit = dh; dREN_dec = dr; dWEN_dec = dw;
        jump_dec = j; jr_dec = jr; branch_taken = br; halt_dec = hd;
    endtask

    // Sample one cycle at the negedge, then advance to just after the next posedge.
    // act: cycle is a FETCH/MEM cycle (counts as a stall when waiting).
    task automatic smp(input string tag, input logic ew, ire, dre, dwe, hlt, input bit act);
        pc_mux_input_selection es;
        @(negedge CLK);
        chk({tag, ".wait"}, 32'(pc_wait), 32'(ew));
        chk({tag, ".iren"}, 32'(imemREN), 32'(ire));
        chk({tag, ".dren"}, 32'(dmemREN), 32'(dre));
        chk({tag, ".dwen"}, 32'(dmemWEN), 32'(dwe));
        chk({tag, ".halt"}, 32'(halt), 32'(hlt));
        es = PC_NPC;
        if (!ew) begin
            chk({tag, ".qnonempty"}, 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) es = exp_q.pop_front();
        end
        chk({tag, ".pcsrc"}, 32'(PCSrc), 32'(es));
        chk({tag, ".icnt"}, 32'(instr_cnt), 32'(m_instr));
        chk({tag, ".scnt"}, 32'(stall_cnt), 32'(m_stall));
`ifdef PCSEQ_PERF_EN
        if (!ew)      m_instr++;
        else if (act) m_stall++;
`endif
        @(posedge CLK); #1;
    endtask

    initial begin
        nRST = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge CLK);
        #1;
        chk("rst.wait", 32'(pc_wait), 32'd1);
        chk("rst.iren", 32'(imemREN), 32'd0);
        chk("rst.dren", 32'(dmemREN), 32'd0);
        chk("rst.dwen", 32'(dmemWEN), 32'd0);
        chk("rst.halt", 32'(halt), 32'd0);
        chk("rst.pcsrc", 32'(PCSrc), 32'(PC_NPC));
        chk("rst.icnt", 32'(instr_cnt), 32'd0);
        nRST = 1'b1;

        // 1: ihit held through IDLE, retires in first FETCH cycle
        drv(1, 0, 0, 0, 0, 0, 0, 0);
        smp("idle", 1, 0, 0, 0, 0, 0);
        exp_q.push_back(PC_NPC);
        smp("npc", 0, 1, 0, 0, 0, 1);

        // dhit alone in FETCH is ignored
        drv(0, 1, 0, 0, 0, 0, 0, 0);
        smp("fetch_dhit", 1, 1, 0, 0, 0, 1);

        // 2: load with jump, dhit after 3 cycles; decode/ihit ignored in MEM
        drv(1, 0, 1, 0, 1, 0, 0, 0);
        exp_q.push_back(PC_JUMP);
        smp("ld_ihit", 1, 1, 0, 0, 0, 1);
        drv(1, 0, 0, 1, 0, 1, 1, 1);
        for (int i = 0; i < 3; i++) smp("ld_mem", 1, 0, 1, 0, 0, 1);
        drv(0, 1, 0, 0, 0, 0, 0, 0);
        smp("ld_dhit", 0, 0, 1, 0, 0, 1);
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        smp("ld_back", 1, 1, 0, 0, 0, 1);

        // 3: selection priority
        drv(1, 0, 0, 0, 1, 1, 1, 0);
        exp_q.push_back(PC_JR);
        smp("jr_prio", 0, 1, 0, 0, 0, 1);
        drv(1, 0, 0, 0, 1, 0, 1, 0);
        exp_q.push_back(PC_JUMP);
        smp("j_prio", 0, 1, 0, 0, 0, 1);
        drv(1, 0, 0, 0, 0, 0, 1, 0);
        exp_q.push_back(PC_BRANCH);
        smp("br", 0, 1, 0, 0, 0, 1);

        // load+store together: read wins, immediate dhit
        drv(1, 0, 1, 1, 0, 0, 1, 0);
        exp_q.push_back(PC_BRANCH);
        smp("rw_ihit", 1, 1, 0, 0, 0, 1);
        drv(0, 1, 0, 0, 0, 0, 0, 0);
        smp("rw_dhit", 0, 0, 1, 0, 0, 1);

        // 5: store, then async reset during MEM drops the access
        drv(1, 0, 0, 1, 0, 0, 0, 0);
        exp_q.push_back(PC_NPC);
        smp("st_ihit", 1, 1, 0, 0, 0, 1);
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        smp("st_mem", 1, 0, 0, 1, 0, 1);
        nRST = 1'b0;
        #1;
        chk("arst.dwen", 32'(dmemWEN), 32'd0);
        chk("arst.wait", 32'(pc_wait), 32'd1);
        chk("arst.iren", 32'(imemREN), 32'd0);
        exp_q.delete();
        m_instr = '0;
        m_stall = '0;
        smp("rst_hold", 1, 0, 0, 0, 0, 0);
        nRST = 1'b1;
        drv(1, 0, 0, 0, 0, 0, 0, 0);
        smp("idle2", 1, 0, 0, 0, 0, 0);

        // 6: 17 back-to-back retirements from a zero count
        for (int i = 0; i < 17; i++) begin
            exp_q.push_back(PC_NPC);
            smp("burst", 0, 1, 0, 0, 0, 1);
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef PCSEQ_PERF_EN
        chk("wrap.icnt", 32'(instr_cnt), 32'd1);
        chk("wrap.scnt", 32'(stall_cnt), 32'd0);
`else
        chk("tied.icnt", 32'(instr_cnt), 32'd0);
        chk("tied.scnt", 32'(stall_cnt), 32'd0);
`endif
        smp("post_burst", 1, 1, 0, 0, 0, 1);

        // 4: halt is terminal; counters freeze
        drv(1, 0, 1, 1, 1, 1, 1, 1);
        smp("halt_ihit", 1, 1, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            drv(1, 1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom));
            smp("halted", 1, 0, 0, 0, 1, 0);
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        chk("q_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
